// File: rtl/tristate_bus_ctrl_pkg.sv
// tristate_bus_ctrl_pkg: state encoding and mux select constants shared by the controller and mux bench
package tristate_bus_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } state_e;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/tristate_bus_ctrl_arb.sv
// arb_rr2: combinational 2-way round-robin pick, ties go to the side that did not own the bus last
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);
  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ~last_owner : req1;
endmodule

// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: round-robin owner FSM for a 2:1 tristate mux with turnaround gap and bus capture
module tristate_bus_ctrl
  import tristate_bus_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bus_in,
  output logic             sel,
  output logic             en,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic last_q, last_d;
  logic sel_q, sel_d;
  logic en_q, gnt0_q, gnt1_q, valid_q;
  logic [WIDTH-1:0] data_q;
  logic own, grant_valid, grant_id;

  assign own = (state_q == OWN0) || (state_q == OWN1);

  arb_rr2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_owner  (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state: arbitrate only in IDLE, rotate on drop or when the hold budget is spent under contention
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !grant_valid ? IDLE : grant_id ? OWN1 : OWN0;
      OWN0:    state_d = (!req0 || (hold_q == HOLD_LAST && req1)) ? TURN : OWN0;
      OWN1:    state_d = (!req1 || (hold_q == HOLD_LAST && req0)) ? TURN : OWN1;
      TURN:    state_d = (turn_q == TURN_LAST) ? IDLE : TURN;
      default: state_d = IDLE;
    endcase
    hold_d = own ? ((hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1) : '0;
    turn_d = (state_q == TURN) ? turn_q + 1'b1 : '0;
    last_d = (state_d == OWN0) ? 1'b0 : (state_d == OWN1) ? 1'b1 : last_q;
    sel_d  = (state_d == OWN0) ? SEL_A : (state_d == OWN1) ? SEL_B : sel_q;
  end

  // State, counters and registered bus controls; bus_in is only sampled while a driver owns the bus
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      turn_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= SEL_A;
      en_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      en_q    <= (state_d == OWN0) || (state_d == OWN1);
      gnt0_q  <= state_d == OWN0;
      gnt1_q  <= state_d == OWN1;
      valid_q <= own;
      if (own) data_q <= bus_in;
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// tb_tristate_bus_ctrl: directed scenarios for the tristate bus controller with a behavioural mux
module tb_tristate_bus_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic sel, en, gnt0, gnt1, data_valid;
  logic [7:0] data_out;
  wire  [7:0] bus = en ? (sel ? b : a) : 8'hzz;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tristate_bus_ctrl #(.WIDTH(8), .MAX_HOLD(4), .TURNAROUND(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0       (req0),
    .req1       (req1),
    .bus_in     (bus),
    .sel        (sel),
    .en         (en),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    a = 8'h3C;
    repeat (3) tick();
    n_cmp++;
    if ({sel, en, gnt0, gnt1, data_valid, data_out} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %b exp 0", {sel, en, gnt0, gnt1, data_valid, data_out});
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, sel, en} !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_first_tie got gnt0,gnt1,sel,en=%b exp 1001", {gnt0, gnt1, sel, en});
    end
    go_idle();
  endtask

  task automatic test_long_burst();
    a = 8'hA5;
    req0 = 1'b1;
    tick();
    n_cmp++;
    if ({en, gnt0, data_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL burst_grant got en,gnt0,dv=%b exp 110", {en, gnt0, data_valid});
    end
    for (int i = 1; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({en, gnt0, gnt1, data_valid, data_out} !== {4'b1101, 8'hA5}) begin
        n_err++;
        $display("FAIL burst_hold i=%0d got en,g0,g1,dv=%b data=%h exp 1101 a5", i, {en, gnt0, gnt1, data_valid}, data_out);
      end
    end
    req0 = 1'b0;
    tick();
    n_cmp++;
    if ({en, gnt0, data_valid, data_out} !== {3'b001, 8'hA5}) begin
      n_err++;
      $display("FAIL burst_turn got en,g0,dv=%b data=%h exp 001 a5", {en, gnt0, data_valid}, data_out);
    end
    tick();
    n_cmp++;
    if ({en, data_valid, data_out} !== {2'b00, 8'hA5}) begin
      n_err++;
      $display("FAIL burst_idle got en,dv=%b data=%h exp 00 a5", {en, data_valid}, data_out);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] own_data, prev_data, exp_data;
    logic exp_en, exp_g0, exp_g1, exp_dv;
    int pos, burst;
    a = 8'h11;
    b = 8'h22;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      pos = c % 6;
      burst = c / 6;
      own_data = (burst % 2 == 0) ? 8'h22 : 8'h11;
      prev_data = (burst == 0) ? 8'hA5 : (burst % 2 == 0) ? 8'h11 : 8'h22;
      exp_en = pos < 4;
      exp_g1 = exp_en && (burst % 2 == 0);
      exp_g0 = exp_en && (burst % 2 == 1);
      exp_dv = (pos >= 1) && (pos <= 4);
      exp_data = (pos == 0) ? prev_data : own_data;
      n_cmp++;
      if ({en, gnt0, gnt1, data_valid, data_out} !== {exp_en, exp_g0, exp_g1, exp_dv, exp_data}) begin
        n_err++;
        $display("FAIL rotate c=%0d got en,g0,g1,dv=%b data=%h exp %b %h", c, {en, gnt0, gnt1, data_valid}, data_out, {exp_en, exp_g0, exp_g1, exp_dv}, exp_data);
      end
      n_cmp++;
      if ((gnt0 & gnt1) !== 1'b0 || en !== (gnt0 | gnt1)) begin
        n_err++;
        $display("FAIL invariant c=%0d got en,g0,g1=%b exp en=g0|g1 and not both", c, {en, gnt0, gnt1});
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    b = 8'h77;
    req1 = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({gnt1, en, sel} !== 3'b111) begin
      n_err++;
      $display("FAIL mid_own1 got g1,en,sel=%b exp 111", {gnt1, en, sel});
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if ({en, gnt1, data_valid, sel, data_out} !== 12'h0) begin
      n_err++;
      $display("FAIL mid_reset got en,g1,dv,sel=%b data=%h exp 0000 00", {en, gnt1, data_valid, sel}, data_out);
    end
    req0 = 1'b1;
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({gnt0, gnt1, sel, en} !== 4'b1001) begin
      n_err++;
      $display("FAIL mid_release got gnt0,gnt1,sel,en=%b exp 1001", {gnt0, gnt1, sel, en});
    end
    go_idle();
  endtask

  task automatic test_min_req();
    b = 8'h5C;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    n_cmp++;
    if ({sel, en, gnt1, data_valid} !== 4'b1110) begin
      n_err++;
      $display("FAIL min_own got sel,en,g1,dv=%b exp 1110", {sel, en, gnt1, data_valid});
    end
    tick();
    n_cmp++;
    if ({sel, en, gnt1, data_valid, data_out} !== {4'b1001, 8'h5C}) begin
      n_err++;
      $display("FAIL min_turn got sel,en,g1,dv=%b data=%h exp 1001 5c", {sel, en, gnt1, data_valid}, data_out);
    end
    tick();
    n_cmp++;
    if ({sel, en, data_valid, data_out} !== {3'b100, 8'h5C}) begin
      n_err++;
      $display("FAIL min_idle got sel,en,dv=%b data=%h exp 100 5c", {sel, en, data_valid}, data_out);
    end
    tick();
    n_cmp++;
    if ({en, data_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL min_stay got en,dv=%b exp 00", {en, data_valid});
    end
  endtask

  initial begin
    test_reset();
    test_long_burst();
    test_rotate();
    test_reset_mid();
    test_min_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tristate_bus_ctrl.md
Name: tristate_bus_ctrl

Overview:
- Upstream controller for the 2:1 tristate bus mux (inputs a/b, sel, dout).
- Arbitrates two requesters round-robin and drives the mux select plus the bus enable.
- Inserts a turnaround gap between bus owners so drivers never overlap.
- Registers the resolved bus value (mux dout fed back) together with a valid strobe.

Parameters:
- WIDTH, 8: bus data width.
- MAX_HOLD, 4: max consecutive owner cycles while the other side is requesting; must be ≥1.
- TURNAROUND, 1: bus-idle cycles (en=0) between owners; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 wants bus (drives mux input a).
- req1  in  1  requester 1 wants bus (drives mux input b).
- bus_in  in  WIDTH  resolved bus value from mux dout.
- sel  out  1  mux select: 0 = a, 1 = b.
- en  out  1  tristate enable: 1 = mux drives bus, 0 = bus Z.
- gnt0  out  1  grant to requester 0.
- gnt1  out  1  grant to requester 1.
- data_out  out  WIDTH  last captured bus value.
- data_valid  out  1  one-cycle-per-beat strobe for data_out.

Behaviour:
- Reset: sampled only on the rising clk edge when reset_n=0.
  - Reset values: state=IDLE, sel=0, en=0, gnt0=0, gnt1=0, data_out=0, data_valid=0, hold_cnt=0, turn_cnt=0.
  - last_owner resets to 1, so requester 0 wins the first tie.
  - Reset mid-ownership: en/gnt drop at that edge with no turnaround.
- All outputs are registered.
- FSM states: IDLE, OWN0, OWN1, TURN.
- IDLE:
  - en=0, gnt=0, sel holds its last value.
  - req0 only -> OWN0; req1 only -> OWN1.
  - Both -> owner = !last_owner.
  - Neither -> stay in IDLE.
  - Grant latency: req high at edge k gives gnt/en/sel valid after edge k+1 (1 cycle).
- OWNx:
  - gntx=1, en=1, sel=x. last_owner <= x on entry. hold_cnt clears on entry and increments each cycle, saturating at MAX_HOLD-1.
  - Exit to TURN when reqx=0.
  - Also exit to TURN when hold_cnt==MAX_HOLD-1 and the other req=1 (forced rotate).
  - If the other side is idle, ownership continues indefinitely with the counter saturated.
  - Both exit conditions in the same cycle: single exit, same result.
- TURN:
  - en=0, gnt0=gnt1=0, sel holds the previous owner.
  - turn_cnt counts TURNAROUND cycles, then -> IDLE.
  - Requests are ignored during TURN; arbitration happens in IDLE only.
- Capture:
  - In every OWNx cycle: data_out <= bus_in, data_valid <= 1 (one cycle later).
  - In all other states: data_valid <= 0 and data_out holds.
  - bus_in is never sampled while en=0, so Z/X must not propagate.
- Invariant: gnt0 & gnt1 is never 1; en == (gnt0 | gnt1).
- Request dropped on the grant cycle: one OWN cycle still occurs (one captured beat), then TURN.

Decomposition:
- Shared include/package: state encoding localparams (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2, TURN=2'd3) and SEL_A=1'b0 / SEL_B=1'b1 constants, reused by the mux bench.
- One natural sub-module: arb_rr2, a combinational 2-way round-robin pick (req0, req1, last_owner -> grant_valid, grant_id). The FSM, counters and capture register stay in tristate_bus_ctrl.

Test Plan:
1. Reset behaviour: hold reset_n=0 3 cycles with req0=req1=1 -> all outputs 0, en=0. Release -> after 1 edge in IDLE, gnt0=1, sel=0, en=1 (requester 0 wins first tie).
2. Single owner, long burst: req0=1 for 10 cycles, req1=0, a=8'hA5 -> gnt0 held 10 cycles with no rotation; data_out=8'hA5 and data_valid=1 lagging en by 1 cycle. req0 drop -> en=0 for exactly 1 TURN cycle, then IDLE.
3. Forced rotate: req0=req1=1 continuously, a=8'h11, b=8'h22. Required pattern: gnt0 for 4 cycles, TURN 1, IDLE 1, gnt1 for 4 cycles, repeating. data_out alternates 8'h11 / 8'h22 bursts, and data_valid is 0 across each gap.
4. Turnaround integrity: check en=0 in every cycle between a gnt0 fall and a gnt1 rise. Check gnt0&gnt1 never 1, and data_out holds (no X) with the mux output at Z.
5. Reset mid-burst: assert reset_n=0 during OWN1 cycle 2 -> next edge en=0, gnt1=0, data_valid=0, data_out=0, sel=0. After release with both requests high -> requester 0 wins.
6. Minimal request: req1 pulsed for 1 cycle -> exactly one OWN1 cycle (sel=1, en=1), one data_valid pulse with data_out=b, then TURN and IDLE.
